uart_block_rx: RTL and testbench

//  Parametrised UART receiver and block assembler for the crypto datapath. Samples uart_rxd
//  at mid-bit and packs BLOCK_BYTES received bytes into one wide block. Presents the block
//  on a valid/ready handshake to the cipher core. Generalises the fixed 115200-baud,
//  16-byte, no-parity path with parity, framing/timeout recovery and overrun detection.

---
 rtl/uart_block_rx.sv | 189 ++++++++++++++++++
 tb/tb_uart_block_rx.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_block_rx.sv
// UART receiver (2-FF sync, mid-bit sampling, optional parity) packing BLOCK_BYTES bytes into one block.
// Latency: blk_valid rises the cycle after the final stop sample. blk_ready never stalls the line; an unread block causes overrun.
module uart_block_rx #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BAUD         = 115_200,
  parameter int BLOCK_BYTES  = 16,
  parameter int PARITY       = 0,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     uart_rxd,
  output logic [8*BLOCK_BYTES-1:0] blk_data,
  output logic                     blk_valid,
  input  logic                     blk_ready,
  output logic                     err_frame,
  output logic                     err_parity,
  output logic                     err_timeout,
  output logic                     err_overrun
);

  localparam int DIV      = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int TW       = $clog2(DIV + 1);
  localparam int IDLE_MAX = TIMEOUT_BITS * DIV;
  localparam int IW       = $clog2(IDLE_MAX + 1);
  localparam int CW       = $clog2(BLOCK_BYTES + 1);
  localparam int AW       = 8 * BLOCK_BYTES;
  localparam logic PAR_ODD = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t state, state_nxt;

  logic          rxd_meta, rxd_sync, rxd_prev;
  logic          fall;
  logic [TW-1:0] bit_tmr;
  logic          tick;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          par_bit;
  logic          par_exp;

  logic          start_seen, data_smp, par_smp, stop_smp;
  logic          frame_bad, parity_bad, byte_ok;

  logic [AW-1:0] asm_q;
  logic [AW-1:0] asm_nxt;
  logic [CW-1:0] byte_cnt;
  logic [IW-1:0] idle_cnt;
  logic          complete, idle_run, timeout_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= uart_rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

  assign fall = rxd_prev & ~rxd_sync;
  assign tick = (bit_tmr == TW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (fall) state_nxt = S_START;
      S_START:  if (tick) state_nxt = rxd_sync ? S_IDLE : S_DATA;
      S_DATA:   if (tick && bit_idx == 3'd7) state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (tick) state_nxt = S_STOP;
      S_STOP:   if (tick) state_nxt = rxd_sync ? S_IDLE : S_BREAK;
      // A low stop bit may be a line break: hold off until the line idles high.
      S_BREAK:  if (rxd_sync) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    start_seen = (state == S_IDLE) && fall;
    data_smp   = (state == S_DATA) && tick;
    par_smp    = (state == S_PARITY) && tick;
    stop_smp   = (state == S_STOP) && tick;
    par_exp    = (^shreg) ^ PAR_ODD;
    frame_bad  = stop_smp && !rxd_sync;
    parity_bad = stop_smp && (PARITY != 0) && (par_bit != par_exp);
    byte_ok    = stop_smp && rxd_sync && !parity_bad;
  end

  // Half-bit load from the edge lands the first sample mid start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_tmr <= '0;
    end else if (state == S_IDLE) begin
      if (fall) bit_tmr <= TW'(DIV / 2);
    end else if (state != S_BREAK) begin
      if (tick) bit_tmr <= TW'(DIV);
      else      bit_tmr <= bit_tmr - TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else begin
      if (state == S_START && tick) bit_idx <= '0;
      if (data_smp) begin
        shreg   <= {rxd_sync, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
      if (par_smp) par_bit <= rxd_sync;
    end
  end

  assign asm_nxt     = (asm_q << 8) | AW'(shreg);
  assign complete    = byte_ok && (byte_cnt == CW'(BLOCK_BYTES - 1));
  assign idle_run    = (state == S_IDLE) && !start_seen && (byte_cnt != '0);
  assign timeout_hit = idle_run && (idle_cnt == IW'(IDLE_MAX - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q    <= '0;
      byte_cnt <= '0;
      idle_cnt <= '0;
    end else if (timeout_hit) begin
      asm_q    <= '0;
      byte_cnt <= '0;
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_run ? idle_cnt + IW'(1) : '0;
      if (byte_ok) begin
        if (complete) begin
          asm_q    <= '0;
          byte_cnt <= '0;
        end else begin
          asm_q    <= asm_nxt;
          byte_cnt <= byte_cnt + CW'(1);
        end
      end
    end
  end

  // Completion coinciding with acceptance reloads the block without dropping valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_data  <= '0;
      blk_valid <= 1'b0;
    end else if (complete && (!blk_valid || blk_ready)) begin
      blk_data  <= asm_nxt;
      blk_valid <= 1'b1;
    end else if (blk_valid && blk_ready) begin
      blk_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_frame   <= 1'b0;
      err_parity  <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      err_frame   <= frame_bad;
      err_parity  <= parity_bad;
      err_timeout <= timeout_hit;
      err_overrun <= complete && blk_valid && !blk_ready;
    end
  end

endmodule

// File: tb/tb_uart_block_rx.sv
// Directed bench for uart_block_rx: a 16-byte no-parity receiver plus a 1-byte odd-parity receiver.
// Baud is raised (DIV = 16) to keep the run short; all bit timings scale with DIV.
module tb_uart_block_rx;

  localparam int CLK_HZ = 50_000_000;
  localparam int BAUD   = 3_125_000;
  localparam int DIV    = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         rxd, rxd_p;
  logic         blk_ready, blk_ready2;
  logic [127:0] blk_data;
  logic         blk_valid;
  logic         err_frame, err_parity, err_timeout, err_overrun;
  logic [7:0]   blk_data2;
  logic         blk_valid2;
  logic         err_frame2, err_parity2, err_timeout2, err_overrun2;

  int n_checks = 0;
  int n_fail   = 0;

  int n_acc = 0, n_frame = 0, n_par = 0, n_to = 0, n_ovr = 0;
  int n_acc2 = 0, n_par2 = 0;
  logic [127:0] last_acc = '0;
  logic [7:0]   last_acc2 = '0;

  int s_acc, s_frame, s_par, s_to, s_ovr, s_acc2, s_par2;

  always #10 clk = ~clk;

  uart_block_rx #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .BLOCK_BYTES(16), .PARITY(0), .TIMEOUT_BITS(20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .uart_rxd(rxd),
    .blk_data(blk_data), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .err_frame(err_frame), .err_parity(err_parity),
    .err_timeout(err_timeout), .err_overrun(err_overrun)
  );

  uart_block_rx #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .BLOCK_BYTES(1), .PARITY(2), .TIMEOUT_BITS(20)
  ) dut_par (
    .clk(clk), .rst_n(rst_n), .uart_rxd(rxd_p),
    .blk_data(blk_data2), .blk_valid(blk_valid2), .blk_ready(blk_ready2),
    .err_frame(err_frame2), .err_parity(err_parity2),
    .err_timeout(err_timeout2), .err_overrun(err_overrun2)
  );

  always @(negedge clk) begin
    if (err_frame)   n_frame <= n_frame + 1;
    if (err_parity)  n_par   <= n_par + 1;
    if (err_timeout) n_to    <= n_to + 1;
    if (err_overrun) n_ovr   <= n_ovr + 1;
    if (blk_valid && blk_ready) begin
      n_acc    <= n_acc + 1;
      last_acc <= blk_data;
    end
    if (err_parity2) n_par2 <= n_par2 + 1;
    if (blk_valid2 && blk_ready2) begin
      n_acc2    <= n_acc2 + 1;
      last_acc2 <= blk_data2;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    s_acc = n_acc; s_frame = n_frame; s_par = n_par; s_to = n_to; s_ovr = n_ovr;
    s_acc2 = n_acc2; s_par2 = n_par2;
  endtask

  task automatic bit_time(input logic v, input logic to_p);
    if (to_p) rxd_p = v;
    else      rxd   = v;
    repeat (DIV) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic to_p, input logic has_par,
                            input logic par, input logic stop);
    bit_time(1'b0, to_p);
    for (int i = 0; i < 8; i++) bit_time(b[i], to_p);
    if (has_par) bit_time(par, to_p);
    bit_time(stop, to_p);
    if (!stop) bit_time(1'b1, to_p);
  endtask

  task automatic send_seq(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) send_frame(first + 8'(i), 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst_n      = 1'b0;
    rxd        = 1'b1;
    rxd_p      = 1'b1;
    blk_ready  = 1'b1;
    blk_ready2 = 1'b1;
    repeat (5) @(negedge clk);
    check("reset blk_valid", 128'(blk_valid), 128'd0);
    check("reset blk_data", blk_data, 128'd0);
    check("reset err", 128'({err_frame, err_parity, err_timeout, err_overrun}), 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk); #1;

    // Plain 16-byte block
    snap();
    send_seq(8'h00, 16);
    repeat (4) @(negedge clk);
    check("t1 blocks", 128'(n_acc - s_acc), 128'd1);
    check("t1 data", last_acc, 128'h000102030405060708090A0B0C0D0E0F);
    check("t1 errs", 128'((n_frame - s_frame) + (n_par - s_par) + (n_to - s_to) + (n_ovr - s_ovr)), 128'd0);
    check("t1 valid low", 128'(blk_valid), 128'd0);

    // Overrun while consumer stalls
    @(posedge clk); #1;
    blk_ready = 1'b0;
    snap();
    send_seq(8'h10, 16);
    repeat (2) @(negedge clk);
    check("t2 valid held", 128'(blk_valid), 128'd1);
    check("t2 first data", blk_data, 128'h101112131415161718191A1B1C1D1E1F);
    send_seq(8'h20, 16);
    repeat (2) @(negedge clk);
    check("t2 data unchanged", blk_data, 128'h101112131415161718191A1B1C1D1E1F);
    check("t2 still valid", 128'(blk_valid), 128'd1);
    check("t2 overrun", 128'(n_ovr - s_ovr), 128'd1);
    @(posedge clk); #1;
    blk_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("t2 valid fell", 128'(blk_valid), 128'd0);
    check("t2 accepted", 128'(n_acc - s_acc), 128'd1);
    check("t2 accepted data", last_acc, 128'h101112131415161718191A1B1C1D1E1F);

    // Framing error drops the byte
    @(posedge clk); #1;
    snap();
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t3 frame err", 128'(n_frame - s_frame), 128'd1);
    send_seq(8'h30, 16);
    repeat (4) @(negedge clk);
    check("t3 block", last_acc, 128'h303132333435363738393A3B3C3D3E3F);
    check("t3 blocks", 128'(n_acc - s_acc), 128'd1);
    check("t3 frame once", 128'(n_frame - s_frame), 128'd1);
    check("t3 no parity err", 128'(n_par - s_par), 128'd0);

    // Odd parity receiver, 0xA5 has four ones
    snap();
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    check("t4 good accepted", 128'(n_acc2 - s_acc2), 128'd1);
    check("t4 good data", 128'(last_acc2), 128'hA5);
    check("t4 good no perr", 128'(n_par2 - s_par2), 128'd0);
    @(posedge clk); #1;
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check("t4 bad perr", 128'(n_par2 - s_par2), 128'd1);
    check("t4 bad dropped", 128'(n_acc2 - s_acc2), 128'd1);

    // Timeout discards a partial block
    @(posedge clk); #1;
    snap();
    send_seq(8'h40, 5);
    repeat (25 * DIV) @(posedge clk);
    #1;
    check("t5 timeout", 128'(n_to - s_to), 128'd1);
    send_seq(8'h00, 16);
    repeat (4) @(negedge clk);
    check("t5 block", last_acc, 128'h000102030405060708090A0B0C0D0E0F);
    check("t5 timeout once", 128'(n_to - s_to), 128'd1);
    check("t5 blocks", 128'(n_acc - s_acc), 128'd1);

    // Short low glitch (quarter bit) must not start a byte
    @(posedge clk); #1;
    snap();
    rxd = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rxd = 1'b1;
    repeat (2 * DIV) @(posedge clk);
    #1;
    send_seq(8'h60, 16);
    repeat (4) @(negedge clk);
    check("t6 glitch block", last_acc, 128'h606162636465666768696A6B6C6D6E6F);
    check("t6 glitch no err", 128'(n_frame - s_frame), 128'd0);

    // Reset in the middle of byte 7
    send_seq(8'h70, 6);
    bit_time(1'b0, 1'b0);
    bit_time(1'b1, 1'b0);
    bit_time(1'b0, 1'b0);
    rst_n = 1'b0;
    rxd   = 1'b1;
    repeat (3) @(negedge clk);
    check("t6 reset valid", 128'(blk_valid), 128'd0);
    check("t6 reset data", blk_data, 128'd0);
    check("t6 reset err", 128'({err_frame, err_parity, err_timeout, err_overrun}), 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2 * DIV) @(posedge clk);
    #1;
    snap();
    send_seq(8'h00, 16);
    repeat (4) @(negedge clk);
    check("t6 clean block", last_acc, 128'h000102030405060708090A0B0C0D0E0F);
    check("t6 clean count", 128'(n_acc - s_acc), 128'd1);
    check("t6 clean errs", 128'((n_frame - s_frame) + (n_par - s_par) + (n_to - s_to) + (n_ovr - s_ovr)), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
